// File: rtl/hpdcache_mshr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hpdcache_mshr_port_arbiter
//  Description : Sequences every access to the single-ported MSHR. Arbitrates
//                between the miss-handler check/alloc requester and the
//                refill-unit ack requester, issuing at most one MSHR command
//                per cycle. A check grant reserves the following cycle (LOCK)
//                so the requester can allocate. Consecutive ack grants while
//                a check waits are bounded by ACK_BURST_MAX. drain_i blocks
//                new checks until the MSHR empties.
//  Ports       :
//    clk_i, rst_ni                      clock, async active-low reset
//    chk_valid_i/chk_ready_o            check handshake (set/tag passed through)
//    chk_rsp_valid_o/chk_hit_o/full_o   check result, cycle after the grant
//    alloc_valid_i/alloc_ready_o        allocate handshake (LOCK cycle only)
//    ack_valid_i/ack_ready_o            ack handshake (set/way passed through)
//    ack_rsp_valid_o                    ack read data valid, cycle after grant
//    drain_i/idle_o                     drain request / drained indication
//    mshr_*                             MSHR command strobes and results
//  Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_mshr_port_arbiter #(
    parameter int unsigned SET_W         = 1,
    parameter int unsigned WAY_W         = 1,
    parameter int unsigned TAG_W         = 32,
    parameter int unsigned ACK_BURST_MAX = 4,
    parameter int unsigned CNT_W         = $clog2(ACK_BURST_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             chk_valid_i,
    output logic             chk_ready_o,
    input  logic [SET_W-1:0] chk_set_i,
    input  logic [TAG_W-1:0] chk_tag_i,
    output logic             chk_rsp_valid_o,
    output logic             chk_hit_o,
    output logic             chk_full_o,

    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,

    input  logic             ack_valid_i,
    output logic             ack_ready_o,
    input  logic [SET_W-1:0] ack_set_i,
    input  logic [WAY_W-1:0] ack_way_i,
    output logic             ack_rsp_valid_o,

    input  logic             drain_i,
    output logic             idle_o,

    output logic             mshr_check_o,
    output logic [SET_W-1:0] mshr_check_set_o,
    output logic [TAG_W-1:0] mshr_check_tag_o,
    input  logic             mshr_hit_i,
    input  logic             mshr_alloc_full_i,
    input  logic             mshr_empty_i,
    output logic             mshr_alloc_o,
    output logic             mshr_alloc_cs_o,
    output logic             mshr_ack_o,
    output logic             mshr_ack_cs_o,
    output logic [SET_W-1:0] mshr_ack_set_o,
    output logic [WAY_W-1:0] mshr_ack_way_o
);

    localparam logic [CNT_W-1:0] c_burst_max = CNT_W'(ACK_BURST_MAX);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_ack_rsp;

    logic             w_ack_gnt;
    logic             w_chk_gnt;
    logic             w_lock;
    logic             w_burst_ok;
    logic             w_chk_pending;

    // A check is "waiting" only when it could actually be granted.
    assign w_chk_pending = chk_valid_i & ~drain_i;
    assign w_burst_ok    = (r_burst_cnt < c_burst_max);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and grants. Grants are gated by rst_ni so that no MSHR
    // strobe leaves the block while reset is asserted, even though the
    // requesters may still be presenting valids.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ack_gnt    = 1'b0;
        w_chk_gnt    = 1'b0;
        w_lock       = 1'b0;
        case (r_state)
            ST_ARB: begin
                w_ack_gnt = rst_ni & ack_valid_i & (w_burst_ok | ~w_chk_pending);
                w_chk_gnt = rst_ni & ~w_ack_gnt & w_chk_pending;
                if (w_chk_gnt) begin
                    w_state_next = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // MSHR read data from the check is being consumed: keep the
                // port quiet except for the optional allocation.
                w_lock       = rst_ni;
                w_state_next = ST_ARB;
            end
            default: begin
                w_state_next = ST_ARB;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Ack burst counter: counts acks that overtook a waiting check.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_burst_cnt <= '0;
        end else if (w_chk_gnt || !w_chk_pending) begin
            r_burst_cnt <= '0;
        end else if (w_ack_gnt && w_burst_ok) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end
    end

    // Ack read data comes back one cycle after the grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack_rsp <= 1'b0;
        end else begin
            r_ack_rsp <= w_ack_gnt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign chk_ready_o      = w_chk_gnt;
    assign ack_ready_o      = w_ack_gnt;
    assign alloc_ready_o    = w_lock;

    assign chk_rsp_valid_o  = w_lock;
    assign chk_hit_o        = w_lock & mshr_hit_i;
    assign chk_full_o       = w_lock & mshr_alloc_full_i;
    assign ack_rsp_valid_o  = r_ack_rsp;

    assign mshr_check_o     = w_chk_gnt;
    assign mshr_check_set_o = chk_set_i;
    assign mshr_check_tag_o = chk_tag_i;
    assign mshr_alloc_o     = w_lock & alloc_valid_i;
    assign mshr_alloc_cs_o  = w_lock & alloc_valid_i;
    assign mshr_ack_o       = w_ack_gnt;
    assign mshr_ack_cs_o    = w_ack_gnt;
    assign mshr_ack_set_o   = ack_set_i;
    assign mshr_ack_way_o   = ack_way_i;

    assign idle_o = drain_i & mshr_empty_i & (r_state == ST_ARB) & ~r_ack_rsp;

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_mshr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hpdcache_mshr_port_arbiter
//  Description : Self-checking bench for hpdcache_mshr_port_arbiter: directed
//                vector table, hand-written multi-cycle sequences and a
//                randomized run against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hpdcache_mshr_port_arbiter;

    localparam int SET_W = 1;
    localparam int WAY_W = 1;
    localparam int TAG_W = 32;
    localparam int BMAX  = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             chk_valid_i, alloc_valid_i, ack_valid_i, drain_i;
    logic [SET_W-1:0] chk_set_i, ack_set_i;
    logic [TAG_W-1:0] chk_tag_i;
    logic [WAY_W-1:0] ack_way_i;
    logic             mshr_hit_i, mshr_alloc_full_i, mshr_empty_i;
    logic             chk_ready_o, chk_rsp_valid_o, chk_hit_o, chk_full_o;
    logic             alloc_ready_o, ack_ready_o, ack_rsp_valid_o, idle_o;
    logic             mshr_check_o, mshr_alloc_o, mshr_alloc_cs_o;
    logic             mshr_ack_o, mshr_ack_cs_o;
    logic [SET_W-1:0] mshr_check_set_o, mshr_ack_set_o;
    logic [TAG_W-1:0] mshr_check_tag_o;
    logic [WAY_W-1:0] mshr_ack_way_o;

    hpdcache_mshr_port_arbiter #(
        .SET_W(SET_W), .WAY_W(WAY_W), .TAG_W(TAG_W), .ACK_BURST_MAX(BMAX)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .chk_valid_i(chk_valid_i), .chk_ready_o(chk_ready_o),
        .chk_set_i(chk_set_i), .chk_tag_i(chk_tag_i),
        .chk_rsp_valid_o(chk_rsp_valid_o), .chk_hit_o(chk_hit_o), .chk_full_o(chk_full_o),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .ack_valid_i(ack_valid_i), .ack_ready_o(ack_ready_o),
        .ack_set_i(ack_set_i), .ack_way_i(ack_way_i), .ack_rsp_valid_o(ack_rsp_valid_o),
        .drain_i(drain_i), .idle_o(idle_o),
        .mshr_check_o(mshr_check_o), .mshr_check_set_o(mshr_check_set_o),
        .mshr_check_tag_o(mshr_check_tag_o), .mshr_hit_i(mshr_hit_i),
        .mshr_alloc_full_i(mshr_alloc_full_i), .mshr_empty_i(mshr_empty_i),
        .mshr_alloc_o(mshr_alloc_o), .mshr_alloc_cs_o(mshr_alloc_cs_o),
        .mshr_ack_o(mshr_ack_o), .mshr_ack_cs_o(mshr_ack_cs_o),
        .mshr_ack_set_o(mshr_ack_set_o), .mshr_ack_way_o(mshr_ack_way_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The cycle after a check grant belongs to the allocator; acks may
    // overtake a waiting check at most BMAX times in a row.
    bit m_after_chk;   // previous cycle granted a check
    int m_overtakes;   // acks granted in a row while a check was waiting
    bit m_ack_prev;    // previous cycle granted an ack

    task automatic model_reset();
        m_after_chk = 0; m_overtakes = 0; m_ack_prev = 0;
    endtask

    // Packed expected vector:
    // {chk_rdy, ack_rdy, alloc_rdy, chk_rsp, hit, full, ack_rsp, idle,
    //  m_check, m_alloc, m_alloc_cs, m_ack, m_ack_cs}
    function automatic logic [12:0] model_out();
        bit waiting, ack_g, chk_g, al;
        waiting = chk_valid_i && !drain_i;
        ack_g = !m_after_chk && ack_valid_i && (m_overtakes < BMAX || !waiting);
        chk_g = !m_after_chk && !ack_g && waiting;
        al    = m_after_chk && alloc_valid_i;
        return {chk_g, ack_g, m_after_chk, m_after_chk, m_after_chk && mshr_hit_i,
                m_after_chk && mshr_alloc_full_i, m_ack_prev,
                drain_i && mshr_empty_i && !m_after_chk && !m_ack_prev,
                chk_g, al, al, ack_g, ack_g};
    endfunction

    function automatic logic [12:0] dut_out();
        return {chk_ready_o, ack_ready_o, alloc_ready_o, chk_rsp_valid_o, chk_hit_o,
                chk_full_o, ack_rsp_valid_o, idle_o, mshr_check_o, mshr_alloc_o,
                mshr_alloc_cs_o, mshr_ack_o, mshr_ack_cs_o};
    endfunction

    // Called at the negedge: compare against the model, then advance it.
    task automatic sample_and_model(input string name);
        logic [12:0] e;
        bit waiting;
        e = model_out();
        check(name, 64'(dut_out()), 64'(e));
        checks++;
        if ($countones({mshr_check_o, mshr_alloc_o, mshr_ack_o}) > 1) begin
            errors++;
            $display("FAIL %s_mutex: strobes %b expected at most one high", name,
                     {mshr_check_o, mshr_alloc_o, mshr_ack_o});
        end
        waiting     = chk_valid_i && !drain_i;
        m_ack_prev  = e[11];
        m_after_chk = e[12];
        if (e[12] || !waiting) m_overtakes = 0;
        else if (e[11])        m_overtakes = (m_overtakes + 1 > BMAX) ? BMAX : m_overtakes + 1;
    endtask

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic set_in(input bit c, input bit a, input bit al, input bit d,
                          input bit e, input bit h);
        chk_valid_i = c; ack_valid_i = a; alloc_valid_i = al;
        drain_i = d; mshr_empty_i = e; mshr_hit_i = h;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        mshr_alloc_full_i = 0;
        chk_set_i = '0; chk_tag_i = '0; ack_set_i = '0; ack_way_i = '0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("reset_outputs", 64'(dut_out()), 64'(0));
        tick();
        rst_ni = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic       c, a, al, d, e, h;
        logic [6:0] exp;  // {chk_rdy, ack_rdy, alloc_rdy, chk_rsp, ack_rsp, idle, hit}
    } tv_t;

    tv_t vec[15];

    initial begin
        int pat[12];
        int code;
        vec[0]  = '{0,0,0,0,1,0, 7'b0000000};  // idle after reset
        vec[1]  = '{1,0,0,0,1,0, 7'b1000000};  // check grant
        vec[2]  = '{0,1,1,0,1,1, 7'b0011001};  // LOCK: alloc, ack held off, hit
        vec[3]  = '{0,1,0,0,1,0, 7'b0100000};  // ack granted next
        vec[4]  = '{0,0,0,0,1,0, 7'b0000100};  // ack response
        vec[5]  = '{1,1,0,0,1,0, 7'b0100000};  // ack burst 1
        vec[6]  = '{1,1,0,0,1,0, 7'b0100100};  // burst 2
        vec[7]  = '{1,1,0,0,1,0, 7'b0100100};  // burst 3
        vec[8]  = '{1,1,0,0,1,0, 7'b0100100};  // burst 4
        vec[9]  = '{1,1,0,0,1,0, 7'b1000100};  // starving check wins
        vec[10] = '{1,1,0,0,1,0, 7'b0011000};  // LOCK
        vec[11] = '{1,1,0,0,1,0, 7'b0100000};  // counter restarted
        vec[12] = '{1,0,0,1,1,0, 7'b0000100};  // drain, ack rsp pending
        vec[13] = '{1,0,0,1,1,0, 7'b0000010};  // idle
        vec[14] = '{1,1,0,1,0,0, 7'b0100000};  // drain lets acks through

        do_reset();
        for (int i = 0; i < 15; i++) begin
            set_in(vec[i].c, vec[i].a, vec[i].al, vec[i].d, vec[i].e, vec[i].h);
            @(negedge clk_i);
            check($sformatf("vec%0d", i),
                  64'({chk_ready_o, ack_ready_o, alloc_ready_o, chk_rsp_valid_o,
                       ack_rsp_valid_o, idle_o, chk_hit_o}), 64'(vec[i].exp));
            sample_and_model($sformatf("vec%0d_model", i));
            tick();
        end

        // ---- burst pattern: 4 acks, 1 check, 1 LOCK, repeating ----
        do_reset();
        for (int i = 0; i < 12; i++) pat[i] = (i % 6 < 4) ? 1 : ((i % 6 == 4) ? 2 : 0);
        for (int i = 0; i < 12; i++) begin
            set_in(1, 1, 1, 0, 0, 0);
            @(negedge clk_i);
            code = mshr_ack_o ? 1 : (mshr_check_o ? 2 : 0);
            check($sformatf("burst_pat%0d", i), 64'(code), 64'(pat[i]));
            sample_and_model("burst_model");
            tick();
        end

        // ---- drain: no checks, idle after last ack response ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, (i < 2), 0, 1, (i >= 2), 0);
            @(negedge clk_i);
            check($sformatf("drain_nochk%0d", i), 64'(chk_ready_o), 64'(0));
            check($sformatf("drain_idle%0d", i), 64'(idle_o), 64'(i >= 3));
            sample_and_model("drain_model");
            tick();
        end

        // ---- reset during LOCK kills the alloc window ----
        do_reset();
        set_in(1, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        sample_and_model("rstlock_grant");
        tick();
        set_in(1, 1, 1, 0, 0, 0);
        @(negedge clk_i);
        check("rstlock_alloc_before", 64'(mshr_alloc_o), 64'(1));
        #1 rst_ni = 1'b0;
        #1;
        check("rstlock_strobes", 64'({mshr_check_o, mshr_alloc_o, mshr_ack_o, alloc_ready_o}),
              64'(0));
        tick();
        check("rstlock_strobes_held",
              64'({mshr_check_o, mshr_alloc_o, mshr_ack_o, alloc_ready_o}), 64'(0));
        do_reset();

        // ---- randomized run ----
        for (int i = 0; i < 10000; i++) begin
            chk_valid_i       = ($urandom_range(0, 3) != 0);
            ack_valid_i       = ($urandom_range(0, 2) != 0);
            alloc_valid_i     = $urandom_range(0, 1) != 0;
            drain_i           = ($urandom_range(0, 9) == 0);
            mshr_empty_i      = $urandom_range(0, 1) != 0;
            mshr_hit_i        = $urandom_range(0, 1) != 0;
            mshr_alloc_full_i = $urandom_range(0, 1) != 0;
            chk_set_i         = SET_W'($urandom);
            chk_tag_i         = TAG_W'($urandom);
            ack_set_i         = SET_W'($urandom);
            ack_way_i         = WAY_W'($urandom);
            @(negedge clk_i);
            sample_and_model("rand");
            check("rand_passthru",
                  64'({mshr_check_set_o, mshr_check_tag_o, mshr_ack_set_o, mshr_ack_way_o}),
                  64'({chk_set_i, chk_tag_i, ack_set_i, ack_way_i}));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
